fetch_unit: RTL and testbench

//   Instruction-fetch stage in front of the decoder. Holds the 8-bit PC and issues one

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/fetch_queue.sv | 81 ++++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : cpu_pkg                                                        |
// | Purpose   : Shared CPU front-end definitions: fetch FSM state encoding,    |
// |             opcode field helpers, HALT opcode and default IMM4 mask.       |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  // Opcode lives in the upper nibble of every instruction byte.
  localparam int OPW = 4;

  // Opcode that stops the fetch stage.
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  // Bit n set => opcode n carries a 4-bit immediate. Shared with the decoder.
  localparam logic [15:0] IMM4_MASK_DEFAULT = 16'h00F0;

  // Depth of the fetch buffer between the memory port and the decoder.
  localparam int QDEPTH = 2;

  // Fetch FSM states.
  //   IDLE  : no request outstanding
  //   WAIT  : request outstanding, response will be buffered
  //   FLUSH : request outstanding, response belongs to a squashed path
  //   HALT  : HALT fetched, no further requests until redirected
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Extract the opcode field from an instruction byte.
  function automatic logic [OPW-1:0] opcode_of(input logic [7:0] inst);
    return inst[7:4];
  endfunction

  // Look up whether an opcode carries a 4-bit immediate.
  function automatic logic opcode_has_imm4(input logic [15:0]    mask,
                                           input logic [OPW-1:0] op);
    return mask[op];
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_queue                                                    |
// | Purpose   : Small FIFO of fetched {pc, inst} pairs between the instruction |
// |             memory port and the decoder. Supports push, pop and a          |
// |             single-cycle flush that discards every buffered entry.         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [AW-1:0] push_pc_i,
  input  logic [7:0]    push_inst_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [AW-1:0] head_pc_o,
  output logic [7:0]    head_inst_o,
  output logic          head_valid_o,
  output logic [1:0]    cnt_o
);

  logic [AW-1:0] pc_q   [QDEPTH];
  logic [7:0]    inst_q [QDEPTH];
  logic          rd_ptr_q;
  logic          wr_ptr_q;
  logic [1:0]    cnt_q;

  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full  = (cnt_q == 2'(QDEPTH));
  assign w_empty = (cnt_q == 2'd0);

  // Flush wins over everything; a push into a full queue is only honoured
  // when the head leaves in the same cycle, so nothing is ever overwritten.
  assign w_do_pop  = pop_i  & ~flush_i & ~w_empty;
  assign w_do_push = push_i & ~flush_i & (~w_full | w_do_pop);

  // Entry storage: written at the tail, no reset needed since cnt gates validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      pc_q[wr_ptr_q]   <= push_pc_i;
      inst_q[wr_ptr_q] <= push_inst_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (w_do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  assign head_pc_o    = pc_q[rd_ptr_q];
  assign head_inst_o  = inst_q[rd_ptr_q];
  assign head_valid_o = ~w_empty;
  assign cnt_o        = cnt_q;

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_unit                                                     |
// | Purpose   : Instruction-fetch stage. Holds the PC, keeps one read in       |
// |             flight to instruction memory, buffers fetched bytes with their |
// |             PC and hands them to the decoder over valid/ready. Handles     |
// |             branch/jump redirects and stops on the HALT opcode.            |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int             AW        = 8,
  parameter logic [AW-1:0]  RESET_PC  = '0,
  parameter logic [OPW-1:0] HALT_OP   = OP_HALT,
  parameter logic [15:0]    IMM4_MASK = IMM4_MASK_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  // instruction memory port
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [7:0]    imem_rdata,
  input  logic          imem_rvalid,
  // control-flow redirect
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  // decoder side
  output logic [7:0]    inst,
  output logic [AW-1:0] inst_pc,
  output logic          isim4,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic          halted
);

  fetch_state_e  state_q;
  logic [AW-1:0] pc_q;
  logic          halted_q;

  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_cnt;
  logic [1:0]    w_cnt_next;
  logic          w_slot_free;
  logic          w_in_flight;
  logic          w_is_halt;

  // Handshake qualifiers. A redirect squashes any same-cycle response.
  assign w_pop  = inst_valid & inst_ready;
  assign w_push = (state_q == ST_WAIT) & imem_rvalid & ~redirect;

  // Occupancy after this cycle; a new read may only be in flight while at
  // least one slot is left for its response.
  assign w_cnt_next  = w_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_slot_free = (w_cnt_next <= 2'd1);

  assign w_in_flight = (state_q == ST_WAIT) | (state_q == ST_FLUSH);
  assign w_is_halt   = (opcode_of(imem_rdata) == HALT_OP);

  // Fetch FSM, PC and halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else if (redirect) begin
      pc_q     <= redirect_pc;
      halted_q <= 1'b0;
      // An unanswered read must still be absorbed before the new path starts.
      if (w_in_flight && !imem_rvalid) begin
        state_q <= ST_FLUSH;
      end else begin
        state_q <= ST_WAIT;
      end
    end else begin
      halted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_slot_free) begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            pc_q <= pc_q + AW'(1);
            if (w_is_halt) begin
              state_q <= ST_HALT;
            end else if (!w_slot_free) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          if (imem_rvalid) begin
            state_q <= ST_WAIT;
          end
        end
        ST_HALT: begin
          halted_q <= (w_cnt_next == 2'd0);
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fetch_queue #(
    .AW (AW)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (w_push),
    .push_pc_i    (pc_q),
    .push_inst_i  (imem_rdata),
    .pop_i        (w_pop),
    .flush_i      (redirect),
    .head_pc_o    (inst_pc),
    .head_inst_o  (inst),
    .head_valid_o (inst_valid),
    .cnt_o        (w_cnt)
  );

  assign imem_req  = w_in_flight;
  assign imem_addr = pc_q;
  assign isim4     = opcode_has_imm4(IMM4_MASK, opcode_of(inst));
  assign halted    = halted_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_fetch_unit                                                  |
// | Purpose   : Directed self-checking bench for fetch_unit with a behavioural |
// |             instruction memory of configurable response latency.          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (RESET_PC = 0)
  logic       rst_n;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_rvalid;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [7:0] inst;
  logic [7:0] inst_pc;
  logic       isim4;
  logic       inst_valid;
  logic       inst_ready;
  logic       halted;

  // second DUT (RESET_PC = 0xFE) for wrap-around
  logic       rst2_n;
  logic       req2;
  logic [7:0] addr2;
  logic [7:0] rdata2;
  logic       rvalid2;
  logic       redirect2;
  logic [7:0] redirect_pc2;
  logic [7:0] inst2;
  logic [7:0] pc2;
  logic       isim2;
  logic       valid2;
  logic       ready2;
  logic       halted2;

  logic [7:0] mem [256];
  int         latency;
  int         lat;
  int         n_cmp;
  int         n_bad;
  int         n_overflow;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .isim4       (isim4),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .halted      (halted)
  );

  fetch_unit #(.RESET_PC(8'hFE)) dut_fe (
    .clk         (clk),
    .rst_n       (rst2_n),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_rdata  (rdata2),
    .imem_rvalid (rvalid2),
    .redirect    (redirect2),
    .redirect_pc (redirect_pc2),
    .inst        (inst2),
    .inst_pc     (pc2),
    .isim4       (isim2),
    .inst_valid  (valid2),
    .inst_ready  (ready2),
    .halted      (halted2)
  );

  // Memory model: response 'latency' cycles after the request first appears.
  always @(negedge clk) begin
    if (!imem_req) lat = 0;
    imem_rvalid = imem_req && (lat >= latency);
    imem_rdata  = mem[imem_addr];
    if (imem_req) lat = imem_rvalid ? 0 : lat + 1;
    rvalid2 = req2;
    rdata2  = mem[addr2];
  end

  // Overflow watch: a push into a full queue without a pop must never happen.
  always @(posedge clk) begin
    if (dut.u_queue.cnt_o == 2'd2 && dut.w_push && !dut.w_pop) n_overflow++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat_cfg, input logic rdy);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    inst_ready  = rdy;
    latency     = lat_cfg;
    cyc();
    cyc();
  endtask

  task automatic test_reset();
    do_reset(0, 1'b1);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
  endtask

  task automatic test_stream();
    logic [16:0] exp;
    do_reset(0, 1'b1);
    rst_n = 1'b1;
    cyc();
    n_cmp++;
    if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL stream_first_req: got v=%b req=%b addr=%h want v=0 req=1 addr=00", inst_valid, imem_req, imem_addr);
    end
    for (int k = 0; k < 6; k++) begin
      cyc();
      exp = {1'b1, 8'(8'h10 + k), 8'(k)};
      n_cmp++;
      if ({inst_valid, inst, inst_pc} !== exp) begin
        n_bad++; $display("FAIL stream_%0d: got v=%b inst=%h pc=%h want %h", k, inst_valid, inst, inst_pc, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] exp;
    do_reset(0, 1'b0);
    rst_n = 1'b1;
    repeat (5) cyc();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_stopped: got %b want 0", imem_req); end
    n_cmp++; if (dut.u_queue.cnt_o !== 2'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", dut.u_queue.cnt_o); end
    n_cmp++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 8'h10, 8'h00}) begin
      n_bad++; $display("FAIL bp_head: got v=%b inst=%h pc=%h want 1/10/00", inst_valid, inst, inst_pc);
    end
    inst_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      exp = {1'b1, 8'(8'h10 + k), 8'(k)};
      n_cmp++;
      if ({inst_valid, inst, inst_pc} !== exp) begin
        n_bad++; $display("FAIL bp_drain_%0d: got v=%b inst=%h pc=%h want %h", k, inst_valid, inst, inst_pc, exp);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic found;
    logic got;
    logic seen5;
    logic [7:0] first_pc;
    logic [7:0] first_inst;
    found = 1'b0; got = 1'b0; seen5 = 1'b0; first_pc = 8'h00; first_inst = 8'h00;
    do_reset(3, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 8'h05) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL inflight_reach_05: got %b want 1", found); end
    n_cmp++; if (imem_rvalid !== 1'b0) begin n_bad++; $display("FAIL inflight_pending: rvalid got %b want 0", imem_rvalid); end
    redirect = 1'b1; redirect_pc = 8'h40;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (inst_valid) begin
        if (inst_pc == 8'h05) seen5 = 1'b1;
        if (!got) begin got = 1'b1; first_pc = inst_pc; first_inst = inst; end
      end
      cyc();
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL inflight_resume: got %b want 1", got); end
    n_cmp++; if (seen5 !== 1'b0) begin n_bad++; $display("FAIL inflight_squash_05: seen %b want 0", seen5); end
    n_cmp++; if (first_pc !== 8'h40) begin n_bad++; $display("FAIL inflight_first_pc: got %h want 40", first_pc); end
    n_cmp++; if (first_inst !== 8'h50) begin n_bad++; $display("FAIL inflight_first_inst: got %h want 50", first_inst); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(0, 1'b1);
    rst_n = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if ({inst_valid, imem_rvalid} !== 2'b11) begin
      n_bad++; $display("FAIL same_precond: got v=%b rvalid=%b want 11", inst_valid, imem_rvalid);
    end
    redirect = 1'b1; redirect_pc = 8'h80;
    cyc();
    redirect = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL same_queue_empty: got %b want 0", inst_valid); end
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h80}) begin
      n_bad++; $display("FAIL same_restart: got req=%b addr=%h want 1/80", imem_req, imem_addr);
    end
    cyc();
    n_cmp++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 8'h90, 8'h80}) begin
      n_bad++; $display("FAIL same_first: got v=%b inst=%h pc=%h want 1/90/80", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    logic [7:0]  pcs [3];
    pcs[0] = 8'hFE; pcs[1] = 8'hFF; pcs[2] = 8'h00;
    rst2_n = 1'b0;
    cyc();
    cyc();
    rst2_n = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      exp = {pcs[k], 8'(pcs[k] + 8'h10)};
      n_cmp++;
      if (!valid2 || {pc2, inst2} !== exp) begin
        n_bad++; $display("FAIL wrap_%0d: got v=%b pc=%h inst=%h want pc/inst %h", k, valid2, pc2, inst2, exp);
      end
    end
    rst2_n = 1'b0;
  endtask

  task automatic test_isim4();
    logic [15:0] mask_ref;
    logic [7:0]  exp_inst;
    int          k;
    mask_ref = 16'h00F0;
    for (int j = 0; j < 16; j++) mem[8'h20 + j] = 8'((j << 4) | 3);
    do_reset(0, 1'b1);
    rst_n = 1'b1;
    cyc();
    redirect = 1'b1; redirect_pc = 8'h20;
    cyc();
    redirect = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 16; i++) begin
      cyc();
      if (inst_valid) begin
        exp_inst = 8'((k << 4) | 3);
        n_cmp++; if (inst !== exp_inst) begin n_bad++; $display("FAIL imm4_inst_%0d: got %h want %h", k, inst, exp_inst); end
        n_cmp++; if (isim4 !== mask_ref[k]) begin n_bad++; $display("FAIL imm4_flag_op%0d: got %b want %b", k, isim4, mask_ref[k]); end
        k++;
      end
    end
    n_cmp++; if (k !== 16) begin n_bad++; $display("FAIL imm4_all_seen: got %0d want 16", k); end
  endtask

  task automatic test_halt();
    logic found;
    int   n_req;
    found = 1'b0;
    mem[3] = 8'hF3;
    do_reset(0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (inst_valid && inst_pc == 8'h03) found = 1'b1;
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL halt_reach_03: got %b want 1", found); end
    n_cmp++;
    if ({inst, imem_req, halted} !== {8'hF3, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL halt_at_03: got inst=%h req=%b halted=%b want F3/0/0", inst, imem_req, halted);
    end
    cyc();
    n_cmp++;
    if ({halted, inst_valid} !== 2'b10) begin
      n_bad++; $display("FAIL halt_drained: got halted=%b v=%b want 1/0", halted, inst_valid);
    end
    n_req = 0;
    repeat (3) begin
      cyc();
      if (imem_req) n_req++;
    end
    n_cmp++; if (n_req !== 0) begin n_bad++; $display("FAIL halt_no_req: got %0d requests want 0", n_req); end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold: got %b want 1", halted); end
    redirect = 1'b1; redirect_pc = 8'h00;
    cyc();
    redirect = 1'b0;
    n_cmp++;
    if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 8'h00}) begin
      n_bad++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h want 0/1/00", halted, imem_req, imem_addr);
    end
    cyc();
    n_cmp++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 8'h10, 8'h00}) begin
      n_bad++; $display("FAIL halt_refetch: got v=%b inst=%h pc=%h want 1/10/00", inst_valid, inst, inst_pc);
    end
    mem[3] = 8'h13;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_overflow = 0; lat = 0; latency = 0;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; inst_ready = 1'b1;
    rst2_n = 1'b0; redirect2 = 1'b0; redirect_pc2 = 8'h00; ready2 = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 8'h00; rvalid2 = 1'b0; rdata2 = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h10);

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_wrap();
    test_isim4();
    test_halt();

    n_cmp++; if (n_overflow !== 0) begin n_bad++; $display("FAIL queue_overflow: got %0d events want 0", n_overflow); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule : tb_fetch_unit
`default_nettype wire
